// File: rtl/back_propagation_hidden_delta_if.sv
`default_nettype none
// ============================================================================
// back_propagation_hidden_delta_if
// Delta-load, weight-stream and hidden-delta result channels.
// Revision: 1.0
// ============================================================================
interface back_propagation_hidden_delta_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 2
);
  logic                   i_delta_valid;
  logic [DATA_WIDTH-1:0]  i_delta;
  logic                   o_delta_ready;
  logic                   i_valid;
  logic [DATA_WIDTH-1:0]  i_weight;
  logic [DATA_WIDTH-1:0]  i_data_node;
  logic                   o_ready;
  logic [DATA_WIDTH-1:0]  o_delta;
  logic                   o_valid;
  logic [INDEX_WIDTH-1:0] o_index;
  logic                   o_done;

  modport slave (
    input  i_delta_valid, i_delta, i_valid, i_weight, i_data_node,
    output o_delta_ready, o_ready, o_delta, o_valid, o_index, o_done
  );

  modport master (
    output i_delta_valid, i_delta, i_valid, i_weight, i_data_node,
    input  o_delta_ready, o_ready, o_delta, o_valid, o_index, o_done
  );
endinterface
`default_nettype wire

// File: rtl/back_propagation_hidden_delta.sv
`default_nettype none
// ============================================================================
// back_propagation_hidden_delta
// Hidden-layer error terms: delta_j = relu'(a_j) * sum_k w_jk * delta_k.
// Revision: 1.0
// ============================================================================
module back_propagation_hidden_delta #(
  parameter int DATA_WIDTH            = 32,
  parameter int FRAC_BITS             = 16,
  parameter int NUMBER_OF_OUTPUT_NODE = 3,
  parameter int NUMBER_OF_HIDDEN_NODE = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  back_propagation_hidden_delta_if.slave bus
);

  localparam int K      = NUMBER_OF_OUTPUT_NODE;
  localparam int J      = NUMBER_OF_HIDDEN_NODE;
  localparam int KW     = (K > 1) ? $clog2(K) : 1;
  localparam int JW     = (J > 1) ? $clog2(J) : 1;
  localparam int ACC_W  = DATA_WIDTH + $clog2(K) + 1;
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic [KW-1:0] c_K_LAST = KW'(K - 1);
  localparam logic [JW-1:0] c_J_LAST = JW'(J - 1);

  localparam logic signed [PROD_W-1:0] c_TERM_MAX =
    {{(PROD_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [PROD_W-1:0] c_TERM_MIN = ~c_TERM_MAX;
  localparam logic signed [ACC_W-1:0]  c_ACC_MAX  = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  c_ACC_MIN  = {1'b1, {(ACC_W - 1){1'b0}}};
  localparam logic signed [ACC_W-1:0]  c_OUT_MAX  =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0]  c_OUT_MIN  = ~c_OUT_MAX;
  localparam logic [DATA_WIDTH-1:0]    c_DW_MAX   = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0]    c_DW_MIN   = {1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_ACCUM = 2'd1,
    S_EMIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                        r_state;
  state_t                        w_state_next;
  logic signed [DATA_WIDTH-1:0]  r_delta_buf [K];
  logic [KW-1:0]                 r_kd;
  logic [KW-1:0]                 r_k;
  logic [JW-1:0]                 r_j;
  logic signed [ACC_W-1:0]       r_acc;
  logic                          r_relu_ok;

  logic                          w_delta_fire;
  logic                          w_beat_fire;
  logic signed [PROD_W-1:0]      w_prod;
  logic signed [PROD_W-1:0]      w_term;
  logic signed [ACC_W-1:0]       w_term_sat;
  logic [ACC_W:0]                w_sum;
  logic signed [ACC_W-1:0]       w_acc_next;
  logic [DATA_WIDTH-1:0]         w_acc_sat;

  assign w_delta_fire = (r_state == S_LOAD)  && bus.i_delta_valid;
  assign w_beat_fire  = (r_state == S_ACCUM) && bus.i_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_LOAD:  if (w_delta_fire && (r_kd == c_K_LAST)) w_state_next = S_ACCUM;
      S_ACCUM: if (w_beat_fire && (r_k == c_K_LAST))   w_state_next = S_EMIT;
      S_EMIT:  w_state_next = (r_j == c_J_LAST) ? S_DONE : S_ACCUM;
      S_DONE:  w_state_next = S_LOAD;
      default: w_state_next = S_LOAD;
    endcase
  end

  // Terms and the running sum clamp at the accumulator range, so an overflowing
  // pass pins at the rail with the correct sign instead of wrapping.
  always_comb begin
    w_prod = $signed(bus.i_weight) * r_delta_buf[r_k];
    w_term = w_prod >>> FRAC_BITS;
    if (w_term > c_TERM_MAX)      w_term_sat = c_ACC_MAX;
    else if (w_term < c_TERM_MIN) w_term_sat = c_ACC_MIN;
    else                          w_term_sat = w_term[ACC_W-1:0];

    w_sum = {r_acc[ACC_W-1], r_acc} + {w_term_sat[ACC_W-1], w_term_sat};
    if (w_sum[ACC_W] != w_sum[ACC_W-1])
      w_acc_next = w_sum[ACC_W] ? c_ACC_MIN : c_ACC_MAX;
    else
      w_acc_next = w_sum[ACC_W-1:0];

    if (r_acc > c_OUT_MAX)      w_acc_sat = c_DW_MAX;
    else if (r_acc < c_OUT_MIN) w_acc_sat = c_DW_MIN;
    else                        w_acc_sat = r_acc[DATA_WIDTH-1:0];
  end

  // Buffer contents are don't-care after reset; the next load overwrites them.
  always_ff @(posedge clk) begin
    if (w_delta_fire) r_delta_buf[r_kd] <= bus.i_delta;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kd      <= '0;
      r_k       <= '0;
      r_j       <= '0;
      r_acc     <= '0;
      r_relu_ok <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_delta_fire) begin
            if (r_kd == c_K_LAST) begin
              r_kd  <= '0;
              r_k   <= '0;
              r_j   <= '0;
              r_acc <= '0;
            end else begin
              r_kd <= r_kd + 1'b1;
            end
          end
        end
        S_ACCUM: begin
          if (w_beat_fire) begin
            r_acc <= w_acc_next;
            if (r_k == '0)
              r_relu_ok <= !bus.i_data_node[DATA_WIDTH-1] && (|bus.i_data_node);
            if (r_k != c_K_LAST) r_k <= r_k + 1'b1;
          end
        end
        S_EMIT: begin
          r_acc <= '0;
          r_k   <= '0;
          if (r_j != c_J_LAST) r_j <= r_j + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_delta_ready = (r_state == S_LOAD);
  assign bus.o_ready       = (r_state == S_ACCUM);
  assign bus.o_valid       = (r_state == S_EMIT);
  assign bus.o_done        = (r_state == S_DONE);
  assign bus.o_index       = r_j;
  assign bus.o_delta       = ((r_state == S_EMIT) && r_relu_ok) ? w_acc_sat : '0;

endmodule
`default_nettype wire

// File: doc/back_propagation_hidden_delta.md
# back_propagation_hidden_delta

Computes the error term of every hidden-layer node from the output-layer deltas. It sits directly downstream of the output-layer back-propagation stage: it consumes the NUMBER_OF_OUTPUT_NODE output deltas that stage produces, then streams in the hidden-to-output weights and hidden activations node by node. For each hidden node j it emits delta_j = relu'(a_j) · Σ_k w_jk·delta_k as signed fixed point, for use by the hidden-layer weight-update stage.

## Interface
- DATA_WIDTH, 32, width of every data word; signed two's complement fixed point.
- FRAC_BITS, 16, fractional bits of the fixed-point format (Q16.16 default).
- NUMBER_OF_OUTPUT_NODE, 3, number of output deltas and weights per hidden node (K).
- NUMBER_OF_HIDDEN_NODE, 4, number of hidden deltas produced per pass (J).
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_delta_valid  in  1  i_delta carries an output-layer delta.
- i_delta  in  DATA_WIDTH  output-layer delta; k = 0..K-1 in arrival order.
- o_delta_ready  out  1  block accepts deltas; a delta transfers when i_delta_valid & o_delta_ready.
- i_valid  in  1  weight beat valid.
- i_weight  in  DATA_WIDTH  w_jk; the beat order is j-major, k-minor.
- i_data_node  in  DATA_WIDTH  hidden activation a_j; sampled only on the k = 0 beat of node j.
- o_ready  out  1  block accepts weight beats; a beat transfers when i_valid & o_ready.
- o_delta  out  DATA_WIDTH  hidden delta delta_j.
- o_valid  out  1  one-cycle pulse; o_delta is valid.
- o_index  out  $clog2(J) (min 1)  hidden node index j of o_delta.
- o_done  out  1  one-cycle pulse in the cycle after the last o_valid of a pass.

## Operation
- FSM states are LOAD, ACCUM, EMIT and DONE.
- **LOAD** (state after reset):
  - o_delta_ready = 1.
  - Each transfer writes delta_buf[kd] and increments kd.
  - On the transfer with kd = K-1: go to ACCUM, clear j, k and the accumulator.
- **ACCUM**:
  - o_ready = 1.
  - Each beat adds (i_weight·delta_buf[k]) >>> FRAC_BITS to the accumulator.
  - The product is the full 2·DATA_WIDTH signed product. The shift is arithmetic, so the result truncates toward −∞.
  - On the k = 0 beat, the block latches relu_ok = (i_data_node > 0), compared as signed.
  - When i_valid is low, the block holds all state.
  - On the beat with k = K-1: go to EMIT. The accumulator includes this final beat.
- **Accumulator**: DATA_WIDTH + $clog2(K) + 1 bits, signed. It never wraps internally.
- **EMIT** (one cycle):
  - o_valid = 1 and o_index = j.
  - o_delta = relu_ok ? sat(acc) : 0.
  - sat clamps to 0x7FFF_FFFF / 0x8000_0000 (scaled to DATA_WIDTH).
  - Clear the accumulator and k.
  - If j = J-1, go to DONE. Otherwise j++ and go to ACCUM.
- **DONE** (one cycle): o_done = 1, then go to LOAD. The delta buffer is overwritten by the next pass.
- **Ignored inputs**:
  - i_delta_valid outside LOAD is ignored.
  - i_valid outside ACCUM is ignored; o_ready is low there.
- **Reset (asserted at any time, including mid-pass)**:
  - FSM returns to LOAD.
  - kd, j, k, the accumulator and relu_ok clear to 0.
  - The partial pass is discarded; no o_valid or o_done follows.
  - delta_buf contents are don't-care.

## Timing
- **Reset values**:
  - o_delta = 0, o_valid = 0, o_index = 0, o_done = 0.
  - o_delta_ready = 1, o_ready = 0.
- **Outputs**: all registered or decoded from state only. No combinational path from any input to any output.
- **LOAD**: takes K accepted deltas. With i_delta_valid held high, o_ready rises in the cycle after the K-th delta.
- **Per hidden node**: K accepted beats, then o_valid in the cycle immediately after the K-th beat. o_ready is low during that EMIT cycle.
- **Minimum pass length**: K + J·(K+1) + 1 cycles, including DONE.
- **Output flow control**: none. The consumer must take o_valid pulses as they arrive.
- **Back-to-back passes**: o_delta_ready rises in the cycle after o_done. No deltas are accepted during DONE.

## Test plan
- **Single pass, Q16.16, K=3, J=4** (all values hex):
  - Deltas 00010000, 00008000, FFFF0000 (1.0, 0.5, −1.0).
  - For every j: weights 00020000, 00040000, 00010000; a_j = 00010000.
  - Each o_delta = 00030000 (2+2−1 = 3.0); o_index 0..3; o_done one cycle after the fourth o_valid.
- **ReLU gate**: same stimulus but a_1 = 0 and a_2 = FFFF8000.
  - o_delta[1] = o_delta[2] = 0; nodes 0 and 3 = 00030000.
- **Saturation**:
  - Deltas all 7FFF0000 with weights all 7FFF0000 → o_delta = 7FFFFFFF.
  - Same with one negated delta per term (all three terms negative) → 80000000.
- **Stalls**: the pass-1 stimulus with i_valid and i_delta_valid toggling in a random 50% pattern.
  - Results are identical to pass 1.
  - No o_valid appears before the K-th beat of each node.
  - o_ready = 0 in every EMIT and DONE cycle.
- **Reset mid-pass**: assert rst for 1 cycle after node 1's second beat.
  - Outputs return to reset values; no o_valid or o_done follows.
  - A fresh full pass afterwards produces the pass-1 results.
- **Back-to-back passes**: two passes with the second delta set 00020000, 00020000, 00020000 and pass-1 weights.
  - The second pass yields 000E0000 for every j (2·(2+4+1) = 14.0).
  - Deltas offered during DONE are not accepted.
